// File: rtl/dram_pkg.sv
// Shared DDR3 command definitions for the initialisation sequencer.
//   cmd_enc_t  : {ras_n, cas_n, we_n} command encoding
//   CMD_*      : NOP, MRS and ZQCL encodings
//   ZQCL_ADDR  : address used for ZQ calibration long (A10 = 1)
//   mrs_ba()   : bank address for each step of the MRS programming order
package dram_pkg;

    typedef logic [2:0] cmd_enc_t;   // {ras_n, cas_n, we_n}

    localparam cmd_enc_t CMD_NOP  = 3'b111;
    localparam cmd_enc_t CMD_MRS  = 3'b000;
    localparam cmd_enc_t CMD_ZQCL = 3'b110;

    localparam logic [15:0] ZQCL_ADDR = 16'h0400;

    // Programming order is MR2, MR3, MR1, MR0.
    function automatic logic [2:0] mrs_ba(input logic [1:0] idx);
        logic [2:0] ba;
        case (idx)
            2'd0:    ba = 3'd2;
            2'd1:    ba = 3'd3;
            2'd2:    ba = 3'd1;
            default: ba = 3'd0;
        endcase
        return ba;
    endfunction

endpackage

// File: rtl/dram_init_seq.sv
// DDR3 power-up initialisation sequencer.
// Drives RESET#/CKE timing, programs MR2/MR3/MR1/MR0, issues ZQCL, then
// raises a sticky init_done.
// Ports:
//   divclk        in   command clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   dram_reset_n  out  DDR3 RESET# level
//   cke           out  DDR3 CKE level
//   cmd_valid     out  command present
//   cmd_ready     in   PHY accepts command
//   cmd_ras_n/cmd_cas_n/cmd_we_n out  command encoding (NOP when idle)
//   cmd_ba        out  bank address
//   cmd_addr      out  address / mode register payload
//   init_done     out  initialisation complete, sticky until reset
//   dbg_state     out  current FSM state
// Handshake: while cmd_valid=1 the command fields are held stable; a rising
// edge with cmd_ready=1 is the acceptance and cmd_valid drops the next
// cycle. cmd_ready is ignored while cmd_valid=0.
module dram_init_seq
    import dram_pkg::*;
#(
    parameter int          T_RESET_CYC  = 40000,
    parameter int          T_CKE_CYC    = 100000,
    parameter int          T_XPR_CYC    = 72,
    parameter int          T_MRD_CYC    = 4,
    parameter int          T_MOD_CYC    = 12,
    parameter int          T_ZQINIT_CYC = 512,
    parameter logic [15:0] MR0          = 16'h0D70,
    parameter logic [15:0] MR1          = 16'h0044,
    parameter logic [15:0] MR2          = 16'h0208,
    parameter logic [15:0] MR3          = 16'h0000
) (
    input  logic        divclk,
    input  logic        reset_n,
    output logic        dram_reset_n,
    output logic        cke,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_ras_n,
    output logic        cmd_cas_n,
    output logic        cmd_we_n,
    output logic [2:0]  cmd_ba,
    output logic [15:0] cmd_addr,
    output logic        init_done,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        RST_HOLD  = 3'd0,
        CKE_WAIT  = 3'd1,
        XPR_WAIT  = 3'd2,
        MRS_ISSUE = 3'd3,
        MRS_WAIT  = 3'd4,
        ZQ_ISSUE  = 3'd5,
        ZQ_WAIT   = 3'd6,
        DONE      = 3'd7
    } state_t;

    // Counter loads: each wait state lasts exactly (parameter) cycles.
    localparam logic [19:0] LD_RESET = 20'(T_RESET_CYC - 1);
    localparam logic [19:0] LD_CKE   = 20'(T_CKE_CYC - 1);
    localparam logic [19:0] LD_XPR   = 20'(T_XPR_CYC - 1);
    localparam logic [19:0] LD_MRD   = 20'(T_MRD_CYC - 1);
    localparam logic [19:0] LD_MOD   = 20'(T_MOD_CYC - 1);
    localparam logic [19:0] LD_ZQ    = 20'(T_ZQINIT_CYC - 1);

    state_t      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;

    logic        dram_reset_n_q, dram_reset_n_d;
    logic        cke_q, cke_d;
    logic        valid_q, valid_d;
    cmd_enc_t    enc_q, enc_d;
    logic [2:0]  ba_q, ba_d;
    logic [15:0] addr_q, addr_d;
    logic        done_q, done_d;

    function automatic logic [15:0] mr_payload(input logic [1:0] idx);
        logic [15:0] v;
        case (idx)
            2'd0:    v = MR2;
            2'd1:    v = MR3;
            2'd2:    v = MR1;
            default: v = MR0;
        endcase
        return v;
    endfunction

    // Next-state logic. The counter is only consumed in wait states, so
    // ISSUE states hold indefinitely without touching it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            RST_HOLD: begin
                if (cnt_q == 20'd0) begin
                    state_d = CKE_WAIT;
                    cnt_d   = LD_CKE;
                end else begin
                    cnt_d = cnt_q - 20'd1;
                end
            end
            CKE_WAIT: begin
                if (cnt_q == 20'd0) begin
                    state_d = XPR_WAIT;
                    cnt_d   = LD_XPR;
                end else begin
                    cnt_d = cnt_q - 20'd1;
                end
            end
            XPR_WAIT: begin
                if (cnt_q == 20'd0) begin
                    state_d = MRS_ISSUE;
                    idx_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q - 20'd1;
                end
            end
            MRS_ISSUE: begin
                if (cmd_ready) begin
                    state_d = MRS_WAIT;
                    cnt_d   = (idx_q == 2'd3) ? LD_MOD : LD_MRD;
                end
            end
            MRS_WAIT: begin
                if (cnt_q == 20'd0) begin
                    if (idx_q == 2'd3) begin
                        state_d = ZQ_ISSUE;
                    end else begin
                        state_d = MRS_ISSUE;
                        idx_d   = idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 20'd1;
                end
            end
            ZQ_ISSUE: begin
                if (cmd_ready) begin
                    state_d = ZQ_WAIT;
                    cnt_d   = LD_ZQ;
                end
            end
            ZQ_WAIT: begin
                if (cnt_q == 20'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 20'd1;
                end
            end
            default: state_d = DONE;
        endcase
    end

    // Outputs are decoded from the next state so they land in flops and
    // line up with the state register cycle for cycle.
    always_comb begin
        dram_reset_n_d = (state_d != RST_HOLD);
        cke_d          = (state_d != RST_HOLD) && (state_d != CKE_WAIT);
        valid_d        = 1'b0;
        enc_d          = CMD_NOP;
        ba_d           = 3'd0;
        addr_d         = 16'h0000;
        done_d         = (state_d == DONE);
        if (state_d == MRS_ISSUE) begin
            valid_d = 1'b1;
            enc_d   = CMD_MRS;
            ba_d    = mrs_ba(idx_d);
            addr_d  = mr_payload(idx_d);
        end else if (state_d == ZQ_ISSUE) begin
            valid_d = 1'b1;
            enc_d   = CMD_ZQCL;
            addr_d  = ZQCL_ADDR;
        end
    end

    always_ff @(posedge divclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= RST_HOLD;
            cnt_q          <= LD_RESET;
            idx_q          <= 2'd0;
            dram_reset_n_q <= 1'b0;
            cke_q          <= 1'b0;
            valid_q        <= 1'b0;
            enc_q          <= CMD_NOP;
            ba_q           <= 3'd0;
            addr_q         <= 16'h0000;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            dram_reset_n_q <= dram_reset_n_d;
            cke_q          <= cke_d;
            valid_q        <= valid_d;
            enc_q          <= enc_d;
            ba_q           <= ba_d;
            addr_q         <= addr_d;
            done_q         <= done_d;
        end
    end

    assign dram_reset_n = dram_reset_n_q;
    assign cke          = cke_q;
    assign cmd_valid    = valid_q;
    assign cmd_ras_n    = enc_q[2];
    assign cmd_cas_n    = enc_q[1];
    assign cmd_we_n     = enc_q[0];
    assign cmd_ba       = ba_q;
    assign cmd_addr     = addr_q;
    assign init_done    = done_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_dram_init_seq.sv
// Testbench for dram_init_seq: expected command stream and event times are
// computed from the timing parameters and pushed into a queue; a monitor
// pops and compares every accepted command.
module tb_dram_init_seq;

    localparam int T_R   = 20;
    localparam int T_C   = 50;
    localparam int T_X   = 10;
    localparam int T_MRD = 4;
    localparam int T_MOD = 12;
    localparam int T_ZQ  = 64;

    // clock / reset
    logic divclk  = 1'b0;
    logic reset_n = 1'b1;
    always #5 divclk = ~divclk;

    logic        cmd_ready = 1'b0;
    logic        dram_reset_n, cke, cmd_valid;
    logic        cmd_ras_n, cmd_cas_n, cmd_we_n;
    logic [2:0]  cmd_ba;
    logic [15:0] cmd_addr;
    logic        init_done;
    logic [2:0]  dbg_state;

    dram_init_seq #(
        .T_RESET_CYC (T_R),
        .T_CKE_CYC   (T_C),
        .T_XPR_CYC   (T_X),
        .T_MRD_CYC   (T_MRD),
        .T_MOD_CYC   (T_MOD),
        .T_ZQINIT_CYC(T_ZQ)
    ) dut (
        .divclk      (divclk),
        .reset_n     (reset_n),
        .dram_reset_n(dram_reset_n),
        .cke         (cke),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_ras_n   (cmd_ras_n),
        .cmd_cas_n   (cmd_cas_n),
        .cmd_we_n    (cmd_we_n),
        .cmd_ba      (cmd_ba),
        .cmd_addr    (cmd_addr),
        .init_done   (init_done),
        .dbg_state   (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // {ras,cas,we, ba, addr, acceptance edge}
    logic [37:0] exp_q[$];

    // rising edges since reset release
    int cyc;
    always @(posedge divclk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    int stall_left[5];
    int cmd_n;
    int exp_rst_rise, exp_cke_rise, exp_done;

    logic [21:0] fields;
    assign fields = {cmd_ras_n, cmd_cas_n, cmd_we_n, cmd_ba, cmd_addr};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // driver: stall each command by its planned count, random ready when idle
    always @(negedge divclk) begin
        if (cmd_valid) begin
            if (cmd_n < 5 && stall_left[cmd_n] > 0) begin
                cmd_ready = 1'b0;
                stall_left[cmd_n]--;
            end else begin
                cmd_ready = 1'b1;
                cmd_n++;
            end
        end else begin
            cmd_ready = 1'($urandom_range(0, 1));
        end
    end

    // monitor / scoreboard
    logic        prev_valid = 1'b0, prev_acc = 1'b0, prev_rstn = 1'b0, prev_cke = 1'b0;
    logic [21:0] prev_fields = '0;
    always @(negedge divclk) begin
        logic [37:0] e;
        #2;
        if (reset_n) begin
            if (cmd_valid) begin
                if (prev_valid && !prev_acc) chk("cmd_stable", fields, prev_fields);
                if (cmd_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_cmd actual=%0h required=none", fields);
                    end else begin
                        e = exp_q.pop_front();
                        chk("cmd_accept", {fields, 16'(cyc + 1)}, e);
                    end
                end
            end else begin
                chk("nop_fields", fields, {3'b111, 3'd0, 16'h0000});
            end
            if (dram_reset_n && !prev_rstn) chk("rst_n_rise_cycle", cyc, exp_rst_rise);
            if (cke && !prev_cke)           chk("cke_rise_cycle", cyc, exp_cke_rise);
        end
        prev_valid  = cmd_valid;
        prev_acc    = cmd_valid && cmd_ready;
        prev_fields = fields;
        prev_rstn   = dram_reset_n;
        prev_cke    = cke;
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_dram_reset_n"}, dram_reset_n, 0);
        chk({tag, "_cke"}, cke, 0);
        chk({tag, "_cmd_valid"}, cmd_valid, 0);
        chk({tag, "_cmd_fields"}, fields, {3'b111, 3'd0, 16'h0000});
        chk({tag, "_init_done"}, init_done, 0);
        chk({tag, "_state"}, dbg_state, 0);
    endtask

    // reference model: event times from the timing rules, then release reset
    task automatic start_seq(input int s0, input int s1, input int s2, input int s3, input int s4);
        int st[5];
        logic [2:0]  ba_t[4];
        logic [15:0] mr_t[4];
        int t, acc;
        st = '{s0, s1, s2, s3, s4};
        ba_t = '{3'd2, 3'd3, 3'd1, 3'd0};
        mr_t = '{16'h0208, 16'h0000, 16'h0044, 16'h0D70};
        exp_q.delete();
        cmd_n = 0;
        stall_left = st;
        exp_rst_rise = T_R;
        exp_cke_rise = T_R + T_C;
        t = T_R + T_C + T_X;
        for (int i = 0; i < 4; i++) begin
            acc = t + 1 + st[i];
            exp_q.push_back({3'b000, ba_t[i], mr_t[i], 16'(acc)});
            t = acc + ((i == 3) ? T_MOD : T_MRD);
        end
        acc = t + 1 + st[4];
        exp_q.push_back({3'b110, 3'd0, 16'h0400, 16'(acc)});
        exp_done = acc + T_ZQ;
        @(negedge divclk);
        #3;
        reset_n = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!init_done && n < 3000) begin
            @(negedge divclk);
            #2;
            n++;
        end
        chk({tag, "_done_reached"}, init_done, 1);
        chk({tag, "_done_cycle"}, cyc, exp_done);
        chk({tag, "_exp_q_drained"}, exp_q.size(), 0);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge divclk);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        exp_q.delete();
        repeat (3) @(negedge divclk);
    endtask

    initial begin
        int n;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge divclk);
        #3;
        check_reset_outputs("por");

        // nominal run, always ready
        start_seq(0, 0, 0, 0, 0);
        wait_done("nominal");

        // MR1 stalled 7 cycles
        apply_reset("rst1");
        start_seq(0, 0, 7, 0, 0);
        wait_done("mr1_stall");

        // random stalls, reset during MRS_WAIT, then full replay
        apply_reset("rst2");
        start_seq($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
                  $urandom_range(0, 5), $urandom_range(0, 5));
        n = 0;
        while (cmd_n < 2 && n < 3000) begin
            @(negedge divclk);
            #1;
            n++;
        end
        chk("abort_reached_mr3", (cmd_n >= 2), 1);
        @(negedge divclk);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        exp_q.delete();
        repeat (3) @(negedge divclk);
        start_seq($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
                  $urandom_range(0, 5), $urandom_range(0, 5));
        wait_done("replay");

        // idle after completion with random ready
        for (int i = 0; i < 1000; i++) begin
            @(negedge divclk);
            #2;
            chk("post_done_init_done", init_done, 1);
            chk("post_done_valid", cmd_valid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
